ssr_mode_scheduler: RTL and testbench
=====================================

SSR_MODE_SCHEDULER -- requirements
Module: ssr_mode_scheduler

Interface
REQ-001 Parameter DEB_CYCLES, default 1000, number of consecutive stable cycles required before a switch change is committed; legal range 2..65535.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 sw  input  6  synchronized local switches {mode_1, mode_2, mode_3A, mode_C, TX, REM}, bit5..bit0.
REQ-005 rem_sw  input  6  remote command word, same bit layout as sw; bit0 ignored.
REQ-006 pri_tick  input  1  one-cycle pulse marking the start of each pulse repetition interval.
REQ-007 enc_ready  input  1  interrogation encoder can accept a mode request.
REQ-008 enc_start  output  1  mode request valid to encoder.
REQ-009 enc_mode  output  2  requested mode: 00=1, 01=2, 10=3A, 11=C.
REQ-010 tx_en  output  1  committed TX enable.
REQ-011 active_modes  output  4  committed {1, 2, 3A, C} enables.
REQ-012 busy  output  1  request outstanding.
REQ-013 skip_cnt  output  8  count of pri_tick pulses lost while a request is outstanding.

Function
REQ-014 Source: src = rem_sw when sw[0]=1, else sw; src[0] forced to the value of sw[0].
REQ-015 Debounce: src sampled into prev_src each cycle; any difference clears a 16-bit stability counter; the counter increments while src==prev_src and saturates at DEB_CYCLES-1.
REQ-016 Commit: cfg loads prev_src on the cycle the stability counter equals DEB_CYCLES-1 and src==prev_src; cfg therefore reflects a new stable src on the (DEB_CYCLES+1)-th rising edge after the change.
REQ-017 active_modes = cfg[5:2]; tx_en = cfg[1]; both registered, no extra latency beyond cfg.
REQ-018 FSM states: IDLE, REQ; busy=1 exactly in REQ; enc_start=1 exactly in REQ.
REQ-019 IDLE -> REQ on pri_tick when tx_en=1 and active_modes!=0; enc_mode loads the selected mode on that edge.
REQ-020 Selection: round-robin in order 1, 2, 3A, C, wrapping; choose the first enabled mode strictly after last_mode, using active_modes at the pri_tick cycle.
REQ-021 Single enabled mode: that mode is selected every interval.
REQ-022 REQ -> IDLE on a cycle with enc_ready=1 (transfer); last_mode <= enc_mode on that edge.
REQ-023 enc_mode remains stable throughout REQ, regardless of cfg changes; new cfg affects only the next selection.
REQ-024 REQ with tx_en=0 and enc_ready=0: request withdrawn, REQ -> IDLE, last_mode unchanged.
REQ-025 REQ with tx_en=0 and enc_ready=1 in the same cycle: transfer completes per REQ-022.
REQ-026 pri_tick while in REQ, including the transfer cycle: no new request is queued; skip_cnt increments, saturating at 255.
REQ-027 pri_tick in IDLE with tx_en=0 or active_modes=0: ignored, skip_cnt unchanged.

Reset
REQ-028 rst low asynchronously forces: prev_src=0, stability counter=0, cfg=0 (tx_en=0, active_modes=0), state IDLE, enc_start=0, busy=0, enc_mode=00, last_mode=11 (so the first selection is mode 1 when enabled), skip_cnt=0.
REQ-029 Reset asserted during REQ drops enc_start immediately, without waiting for a clock edge; no transfer is counted.
REQ-030 After rst deasserts, operation begins on the first rising edge; cfg stays 0 until REQ-016 is satisfied.

Verification (DEB_CYCLES=4)
REQ-031 sw=6'b111110 held from reset release -> tx_en=1 and active_modes=4'b1111 on edge 5; sw toggled back within 3 cycles -> cfg unchanged.
REQ-032 All modes enabled, enc_ready=1, eight pri_ticks spaced 10 cycles apart -> enc_mode sequence 00, 01, 10, 11, 00, 01, 10, 11; each enc_start lasts 1 cycle.
REQ-033 Only 3A and C enabled, last_mode=10 -> next enc_mode=11, then 10.
REQ-034 enc_ready=0 for 30 cycles across 3 pri_ticks while in REQ -> skip_cnt=3, enc_mode stable, single transfer when enc_ready rises.
REQ-035 sw[0]=1, rem_sw=6'b010011 -> after debounce only mode 2 issued, tx_en=1; TX switched off during REQ with enc_ready=0 -> enc_start drops next edge, last_mode unchanged.
REQ-036 rst pulsed low mid-REQ -> enc_start=0 asynchronously; all outputs at REQ-028 values; the first selection after re-commit is mode 1.

Source files
------------

// File: rtl/ssr_mode_scheduler_if.sv
// Switch inputs and encoder handshake of the SSR mode scheduler, bundled for the
// scheduler (slave) and whatever drives it (master).
interface ssr_mode_scheduler_if;
  logic [5:0] sw;
  logic [5:0] rem_sw;
  logic       pri_tick;
  logic       enc_ready;
  logic       enc_start;
  logic [1:0] enc_mode;
  logic       tx_en;
  logic [3:0] active_modes;
  logic       busy;
  logic [7:0] skip_cnt;

  modport master (
    output sw, rem_sw, pri_tick, enc_ready,
    input  enc_start, enc_mode, tx_en, active_modes, busy, skip_cnt
  );

  modport slave (
    input  sw, rem_sw, pri_tick, enc_ready,
    output enc_start, enc_mode, tx_en, active_modes, busy, skip_cnt
  );
endinterface

// File: rtl/ssr_mode_scheduler.sv
// SSR interrogation mode scheduler: debounces local/remote switch settings and issues
// one round-robin mode request per pulse repetition interval to the encoder.
module ssr_mode_scheduler #(
  parameter int unsigned DEB_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  rst,
  ssr_mode_scheduler_if.slave  bus
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SRC_W  = 6;
  localparam int unsigned SKIP_W = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX = '1;

  typedef enum logic {IDLE, REQ} state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   src_c;
  logic [SRC_W-1:0]   prev_src_q;
  logic [SRC_W-1:0]   cfg_q, cfg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         enc_mode_q, enc_mode_d;
  logic [1:0]         last_mode_q, last_mode_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  logic               enc_start_q, busy_q;
  logic               tx_en_c;
  logic [3:0]         active_c;
  logic [1:0]         sel_c;
  logic [1:0]         cand_c;
  logic               found_c;

  // REM (bit0) always comes from the local panel, even when remote control is selected
  always_comb begin
    src_c    = bus.sw[0] ? bus.rem_sw : bus.sw;
    src_c[0] = bus.sw[0];
  end

  always_comb begin
    cnt_d = cnt_q;
    cfg_d = cfg_q;
    if (src_c != prev_src_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cfg_d = prev_src_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign tx_en_c  = cfg_q[1];
  assign active_c = cfg_q[5:2];

  // First enabled mode strictly after last_mode; active_c[3] is mode 1, active_c[0] is mode C
  always_comb begin
    sel_c   = last_mode_q;
    cand_c  = last_mode_q;
    found_c = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand_c = last_mode_q + 2'(k);
      if (!found_c && active_c[2'd3 - cand_c]) begin
        sel_c   = cand_c;
        found_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    enc_mode_d  = enc_mode_q;
    last_mode_d = last_mode_q;
    skip_d      = skip_q;
    case (state_q)
      IDLE: begin
        if (bus.pri_tick && tx_en_c && (active_c != 4'd0)) begin
          state_d    = REQ;
          enc_mode_d = sel_c;
        end
      end
      REQ: begin
        if (bus.pri_tick && (skip_q != SKIP_MAX)) skip_d = skip_q + SKIP_W'(1);
        if (bus.enc_ready) begin
          state_d     = IDLE;
          last_mode_d = enc_mode_q;
        end else if (!tx_en_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_src_q  <= '0;
      cnt_q       <= '0;
      cfg_q       <= '0;
      state_q     <= IDLE;
      enc_mode_q  <= 2'b00;
      last_mode_q <= 2'b11;
      skip_q      <= '0;
      enc_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      prev_src_q  <= src_c;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      state_q     <= state_d;
      enc_mode_q  <= enc_mode_d;
      last_mode_q <= last_mode_d;
      skip_q      <= skip_d;
      enc_start_q <= (state_d == REQ);
      busy_q      <= (state_d == REQ);
    end
  end

  assign bus.enc_start    = enc_start_q;
  assign bus.busy         = busy_q;
  assign bus.enc_mode     = enc_mode_q;
  assign bus.tx_en        = tx_en_c;
  assign bus.active_modes = active_c;
  assign bus.skip_cnt     = skip_q;

endmodule

// File: tb/tb_ssr_mode_scheduler.sv
// Directed bench for ssr_mode_scheduler with DEB_CYCLES=4: debounce timing, round-robin
// selection, skip counting, withdrawal and asynchronous reset.
module tb_ssr_mode_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ssr_mode_scheduler_if bus_if ();

  ssr_mode_scheduler #(.DEB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // pri_tick pulse on one edge, then check the request it raised
  task automatic request(input string tag, input logic [1:0] exp_mode);
    bus_if.pri_tick = 1'b1;
    tick(1);
    bus_if.pri_tick = 1'b0;
    check({tag, "_start"}, 8'(bus_if.enc_start), 8'd1);
    check({tag, "_mode"}, 8'(bus_if.enc_mode), 8'(exp_mode));
  endtask

  logic       stable;
  logic [1:0] rr_exp [8];

  initial begin
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    bus_if.sw        = 6'b000000;
    bus_if.rem_sw    = 6'b000000;
    bus_if.pri_tick  = 1'b0;
    bus_if.enc_ready = 1'b0;
    tick(2);
    check("rst_start", 8'(bus_if.enc_start), 8'd0);
    check("rst_busy", 8'(bus_if.busy), 8'd0);
    check("rst_mode", 8'(bus_if.enc_mode), 8'd0);
    check("rst_tx", 8'(bus_if.tx_en), 8'd0);
    check("rst_active", 8'(bus_if.active_modes), 8'd0);
    check("rst_skip", bus_if.skip_cnt, 8'd0);

    // Debounce: commit lands on edge 5 after release
    bus_if.sw = 6'b111110;
    rst = 1'b1;
    tick(4);
    check("deb_edge4_tx", 8'(bus_if.tx_en), 8'd0);
    tick(1);
    check("deb_edge5_tx", 8'(bus_if.tx_en), 8'd1);
    check("deb_edge5_active", 8'(bus_if.active_modes), 8'hF);
    bus_if.sw = 6'b000010;
    tick(3);
    bus_if.sw = 6'b111110;
    tick(6);
    check("glitch_active", 8'(bus_if.active_modes), 8'hF);
    check("glitch_tx", 8'(bus_if.tx_en), 8'd1);

    // Full round-robin with a ready encoder
    bus_if.enc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      request($sformatf("rr%0d", i), rr_exp[i]);
      tick(1);
      check($sformatf("rr%0d_drop", i), 8'(bus_if.enc_start), 8'd0);
      tick(8);
    end
    check("rr_skip", bus_if.skip_cnt, 8'd0);

    // Only 3A and C enabled: 3A, C, 3A after last=C
    bus_if.sw = 6'b001110;
    tick(6);
    check("two_active", 8'(bus_if.active_modes), 8'h3);
    request("two0", 2'd2); tick(3);
    request("two1", 2'd3); tick(3);
    request("two2", 2'd2); tick(3);

    // Encoder stalls across three PRIs
    bus_if.enc_ready = 1'b0;
    request("stall", 2'd3);
    stable = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      bus_if.pri_tick = (i % 10 == 0);
      tick(1);
      if (bus_if.enc_mode !== 2'd3 || bus_if.enc_start !== 1'b1) stable = 1'b0;
    end
    bus_if.pri_tick = 1'b0;
    check("stall_stable", 8'(stable), 8'd1);
    check("stall_skip3", bus_if.skip_cnt, 8'd3);
    bus_if.enc_ready = 1'b1;
    bus_if.pri_tick  = 1'b1;
    tick(1);
    bus_if.pri_tick = 1'b0;
    check("xfer_drop", 8'(bus_if.enc_start), 8'd0);
    check("xfer_skip4", bus_if.skip_cnt, 8'd4);
    tick(3);
    check("no_queue", 8'(bus_if.enc_start), 8'd0);
    request("after_stall", 2'd2);
    tick(3);

    // Remote control: only mode 2 offered
    bus_if.sw     = 6'b000001;
    bus_if.rem_sw = 6'b010011;
    tick(6);
    check("rem_active", 8'(bus_if.active_modes), 8'h4);
    check("rem_tx", 8'(bus_if.tx_en), 8'd1);
    request("rem0", 2'd1); tick(3);
    request("rem1", 2'd1); tick(3);

    // Withdraw a 3A request by dropping TX; last_mode must stay at mode 2
    bus_if.rem_sw = 6'b011011;
    tick(6);
    check("rem2_active", 8'(bus_if.active_modes), 8'h6);
    bus_if.enc_ready = 1'b0;
    request("wd_req", 2'd2);
    bus_if.rem_sw = 6'b011001;
    tick(5);
    check("wd_tx_off", 8'(bus_if.tx_en), 8'd0);
    check("wd_still_req", 8'(bus_if.enc_start), 8'd1);
    tick(1);
    check("wd_drop", 8'(bus_if.enc_start), 8'd0);
    check("wd_busy", 8'(bus_if.busy), 8'd0);
    bus_if.pri_tick = 1'b1;
    tick(1);
    bus_if.pri_tick = 1'b0;
    check("idle_ign_start", 8'(bus_if.enc_start), 8'd0);
    check("idle_ign_skip", bus_if.skip_cnt, 8'd4);
    bus_if.rem_sw = 6'b011011;
    tick(6);
    bus_if.enc_ready = 1'b1;
    request("wd_last", 2'd2);
    tick(3);

    // Asynchronous reset in the middle of a request
    bus_if.enc_ready = 1'b0;
    request("pre_rst", 2'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_start", 8'(bus_if.enc_start), 8'd0);
    check("arst_busy", 8'(bus_if.busy), 8'd0);
    check("arst_mode", 8'(bus_if.enc_mode), 8'd0);
    check("arst_tx", 8'(bus_if.tx_en), 8'd0);
    check("arst_active", 8'(bus_if.active_modes), 8'd0);
    check("arst_skip", bus_if.skip_cnt, 8'd0);
    bus_if.sw     = 6'b111110;
    bus_if.rem_sw = 6'b000000;
    #2 rst = 1'b1;
    tick(4);
    check("re_edge4_tx", 8'(bus_if.tx_en), 8'd0);
    tick(1);
    check("re_active", 8'(bus_if.active_modes), 8'hF);
    bus_if.enc_ready = 1'b1;
    request("re_first", 2'd0);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
